// File: rtl/psi_input_loader.sv
// -----------------------------------------------------------------------------
// psi_input_loader
//
// Upstream feeder for the bitonic PSI core. Party set elements arrive one
// W-bit word per cycle on a valid/ready stream: party 0 first, with each
// party's K words in order. The loader assembles them into the flat W*K*N-bit
// p_input vector. The first word goes into the most-significant slot, so the
// frame reads as an MSB-first concatenation of the stream.
//
// While loading, the loader checks that each party's words are strictly
// ascending. A violation raises the advisory flag order_err. The flag does
// not stop the frame from completing.
//
// Once the frame is full, p_input is held stable with p_valid high until the
// consumer pulses p_ack. The loader then returns to LOAD and accepts the next
// frame.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   clr        in   1        synchronous abort of the partial or held frame
//   in_valid   in   1        in_data holds a valid element
//   in_data    in   W        element word
//   in_ready   out  1        loader accepts a word this cycle (state LOAD)
//   p_input    out  W*K*N    assembled frame for the PSI core
//   p_valid    out  1        p_input complete and stable (state FULL)
//   p_ack      in   1        consumer has taken p_input
//   order_err  out  1        sticky: some party's set was not strictly ascending
// -----------------------------------------------------------------------------
module psi_input_loader #(
  parameter int W = 4,
  parameter int K = 4,
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic [W*K*N-1:0] p_input,
  output logic             p_valid,
  input  logic             p_ack,
  output logic             order_err
);

  localparam int NK = N * K;
  localparam int CW = (NK > 1) ? $clog2(NK) : 1;
  localparam int EW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_FULL = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   elem_cnt_q, elem_cnt_d;
  logic [PW-1:0]   party_cnt_q, party_cnt_d;
  logic [W-1:0]    prev_q, prev_d;
  logic [W*NK-1:0] p_input_q, p_input_d;
  logic            order_err_q, order_err_d;

  logic            accept;
  logic            last_elem;
  logic            last_party;
  logic [CW-1:0]   word_idx;

  // Handshake signals decode straight from state, with no combinational path
  // from the inputs.
  assign in_ready  = (state_q == S_LOAD);
  assign p_valid   = (state_q == S_FULL);
  assign p_input   = p_input_q;
  assign order_err = order_err_q;

  assign accept     = in_valid && in_ready;
  assign last_elem  = (elem_cnt_q == EW'(K - 1));
  assign last_party = (party_cnt_q == PW'(N - 1));
  // Running index of the word being accepted, 0 .. N*K-1.
  assign word_idx   = CW'(party_cnt_q) * CW'(K) + CW'(elem_cnt_q);

  // NOTE: every variable is given its hold value before any branch. A path that
  // leaves one unassigned would infer a latch instead of the intended mux.
  always_comb begin
    state_d     = state_q;
    elem_cnt_d  = elem_cnt_q;
    party_cnt_d = party_cnt_q;
    prev_d      = prev_q;
    p_input_d   = p_input_q;
    order_err_d = order_err_q;

    if (clr) begin
      // Abort wins over everything, including a word offered this cycle.
      state_d     = S_LOAD;
      elem_cnt_d  = '0;
      party_cnt_d = '0;
      prev_d      = '0;
      p_input_d   = '0;
      order_err_d = 1'b0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (accept) begin
            prev_d = in_data;
            // Word c lands in slot NK-1-c, so the first word fills the MS slot.
            for (int i = 0; i < NK; i++) begin
              if (word_idx == CW'(NK - 1 - i)) begin
                p_input_d[i*W +: W] = in_data;
              end
            end
            // No check applies on a party's first word. A drop across a party
            // boundary is legal.
            if ((elem_cnt_q != '0) && (in_data <= prev_q)) begin
              order_err_d = 1'b1;
            end
            if (last_elem) begin
              elem_cnt_d = '0;
              if (last_party) begin
                party_cnt_d = '0;
                state_d     = S_FULL;
              end else begin
                party_cnt_d = party_cnt_q + PW'(1);
              end
            end else begin
              elem_cnt_d = elem_cnt_q + EW'(1);
            end
          end
        end
        S_FULL: begin
          // The frame and error flag are frozen. p_input keeps its value after
          // release and is overwritten word by word by the next frame.
          if (p_ack) begin
            state_d     = S_LOAD;
            elem_cnt_d  = '0;
            party_cnt_d = '0;
            order_err_d = 1'b0;
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments. All flops then sample
  // the pre-edge values, whatever order the simulator runs the processes in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      elem_cnt_q  <= '0;
      party_cnt_q <= '0;
      prev_q      <= '0;
      p_input_q   <= '0;
      order_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_cnt_q  <= elem_cnt_d;
      party_cnt_q <= party_cnt_d;
      prev_q      <= prev_d;
      p_input_q   <= p_input_d;
      order_err_q <= order_err_d;
    end
  end

endmodule
